// File: rtl/boot_rom_pkg.sv
// Shared types and defaults for the boot ROM arbiter slice.
package boot_rom_pkg;

  localparam int ROM_WORDS_DEF = 800;
  localparam int ROM_AW_DEF    = 10;

  // 0 = core instruction fetch, 1 = debug/data read path
  typedef logic owner_t;

  typedef struct packed {
    logic   v;
    owner_t owner;
    logic   err;
  } rom_resp_t;

endpackage

// File: rtl/boot_rom_arbiter_rr_arb2.sv
// Two-way combinational picker: round-robin against the previous owner, or port 0 first.
module rr_arb2
  import boot_rom_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  input  logic       rr_en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      if (rr_en && (last == 1'b0)) begin
        gnt = 2'b10;
      end else begin
        gnt = 2'b01;
      end
    end
  end

endmodule

// File: rtl/boot_rom_arbiter.sv
// Shares the single-ported boot ROM between instruction fetch (port 0) and debug reads (port 1).
module boot_rom_arbiter
  import boot_rom_pkg::*;
#(
  parameter int ROM_WORDS = ROM_WORDS_DEF,
  parameter int ROM_AW    = ROM_AW_DEF,
  parameter bit RR_EN     = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              m0_req,
  input  logic [31:0]       m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [31:0]       m1_addr,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              rom_csn,
  output logic [ROM_AW-1:0] rom_a,
  input  logic [31:0]       rom_q
);

  localparam logic [ROM_AW:0] WORDS_LIM = (ROM_AW+1)'(ROM_WORDS);

  logic [1:0]        gnt_p0;
  owner_t            last_owner;
  owner_t            sel_p0;
  logic              vld_p0;
  logic [31:0]       addr_p0;
  logic [ROM_AW-1:0] word_p0;
  logic              in_range_p0;
  logic              issue_p0;
  logic [ROM_AW-1:0] rom_a_q;
  rom_resp_t         resp_p1;
  logic              own0_p1;
  logic              own1_p1;
  logic              unused_addr_bits;

  rr_arb2 u_arb (
    .req   ({m1_req, m0_req}),
    .last  (last_owner),
    .rr_en (RR_EN),
    .gnt   (gnt_p0)
  );

  // Stage p0: grant, address select, range check and ROM issue
  assign sel_p0      = gnt_p0[1];
  assign vld_p0      = |gnt_p0;
  assign addr_p0     = sel_p0 ? m1_addr : m0_addr;
  assign word_p0     = addr_p0[ROM_AW+1:2];
  assign in_range_p0 = ({1'b0, word_p0} < WORDS_LIM);
  assign issue_p0    = vld_p0 & in_range_p0;

  // Byte-lane and high address bits never reach the ROM or the range check
  assign unused_addr_bits = ^{addr_p0[31:ROM_AW+2], addr_p0[1:0]};

  assign m0_gnt  = gnt_p0[0];
  assign m1_gnt  = gnt_p0[1];
  assign rom_csn = ~issue_p0;
  // Out-of-range grants leave the ROM address where the last real access put it
  assign rom_a   = issue_p0 ? word_p0 : rom_a_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_owner <= 1'b1;
      rom_a_q    <= '0;
      resp_p1    <= '0;
    end else begin
      if (vld_p0) begin
        last_owner <= sel_p0;
      end
      if (issue_p0) begin
        rom_a_q <= word_p0;
      end
      resp_p1 <= '{v: vld_p0, owner: sel_p0, err: ~in_range_p0};
    end
  end

  // Stage p1: route the ROM word or the error response back to the owner
  assign own0_p1   = resp_p1.v & (resp_p1.owner == 1'b0);
  assign own1_p1   = resp_p1.v & (resp_p1.owner == 1'b1);
  assign m0_rvalid = own0_p1;
  assign m1_rvalid = own1_p1;
  assign m0_err    = own0_p1 & resp_p1.err;
  assign m1_err    = own1_p1 & resp_p1.err;
  assign m0_rdata  = (own0_p1 && !resp_p1.err) ? rom_q : 32'h0;
  assign m1_rdata  = (own1_p1 && !resp_p1.err) ? rom_q : 32'h0;

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Scoreboard bench for boot_rom_arbiter: round-robin instance under random and directed traffic,
// plus a fixed-priority instance exercised directly.
module tb_boot_rom_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        m0_req = 0, m1_req = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        rom_csn;
  logic [9:0]  rom_a;
  logic [31:0] rom_q = 0;

  logic        f0_req = 0, f1_req = 0;
  logic [31:0] f0_addr = 0, f1_addr = 0;
  logic        fp_m0_gnt, fp_m1_gnt, fp_m0_rvalid, fp_m1_rvalid, fp_m0_err, fp_m1_err;
  logic [31:0] fp_m0_rdata, fp_m1_rdata;
  logic        fp_csn;
  logic [9:0]  fp_a;
  logic [31:0] fp_q = 0;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  always #5 CLK = ~CLK;

  boot_rom_arbiter #(.ROM_WORDS(800), .ROM_AW(10), .RR_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .rom_csn(rom_csn), .rom_a(rom_a), .rom_q(rom_q)
  );

  boot_rom_arbiter #(.ROM_WORDS(800), .ROM_AW(10), .RR_EN(1'b0)) dut_fp (
    .CLK(CLK), .RST(RST),
    .m0_req(f0_req), .m0_addr(f0_addr), .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid),
    .m0_rdata(fp_m0_rdata), .m0_err(fp_m0_err),
    .m1_req(f1_req), .m1_addr(f1_addr), .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid),
    .m1_rdata(fp_m1_rdata), .m1_err(fp_m1_err),
    .rom_csn(fp_csn), .rom_a(fp_a), .rom_q(fp_q)
  );

  // ROM contents: fixed words at the addresses the directed tests use, a hash elsewhere
  function automatic logic [31:0] rom_word(input int idx);
    if (idx == 0)                  return 32'h0000_0013;
    else if (idx == 31 || idx == 32) return 32'h0100_006F;
    else                           return (idx * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  always @(posedge CLK) begin
    cycle <= cycle + 1;
    if (!rom_csn) rom_q <= rom_word(int'(rom_a));
    if (!fp_csn)  fp_q  <= rom_word(int'(fp_a));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: arbitration state and expected responses
  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   last_owner = 1;
  int   last_a     = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      int g;
      int word;
      logic [31:0] a;
      g = -1;
      if (m0_req && m1_req) g = (last_owner == 0) ? 1 : 0;
      else if (m0_req)      g = 0;
      else if (m1_req)      g = 1;
      chk("m0_gnt", {31'b0, m0_gnt}, {31'b0, g == 0});
      chk("m1_gnt", {31'b0, m1_gnt}, {31'b0, g == 1});
      if (g >= 0) begin
        a = (g == 1) ? m1_addr : m0_addr;
        word = int'((a >> 2) % 1024);
        if (word < 800) begin
          chk("rom_csn_issue", {31'b0, rom_csn}, 32'd0);
          chk("rom_a_issue", {22'b0, rom_a}, word);
          sb.push_back('{port: g, data: rom_word(word), err: 1'b0, due: cycle + 1});
          last_a = word;
        end else begin
          chk("rom_csn_oor", {31'b0, rom_csn}, 32'd1);
          chk("rom_a_oor_hold", {22'b0, rom_a}, last_a);
          sb.push_back('{port: g, data: 32'h0, err: 1'b1, due: cycle + 1});
        end
        last_owner = g;
      end else begin
        chk("rom_csn_idle", {31'b0, rom_csn}, 32'd1);
        chk("rom_a_idle_hold", {22'b0, rom_a}, last_a);
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a response is due
  always @(negedge CLK) begin
    if (!RST) begin
      if (sb.size() > 0 && sb[0].due == cycle) begin
        exp_t e;
        e = sb.pop_front();
        chk("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, e.port == 0});
        chk("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, e.port == 1});
        if (e.port == 0) begin
          chk("m0_rdata", m0_rdata, e.data);
          chk("m0_err", {31'b0, m0_err}, {31'b0, e.err});
        end else begin
          chk("m1_rdata", m1_rdata, e.data);
          chk("m1_err", {31'b0, m1_err}, {31'b0, e.err});
        end
      end else begin
        chk("m0_rvalid_idle", {31'b0, m0_rvalid}, 32'd0);
        chk("m1_rvalid_idle", {31'b0, m1_rvalid}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    RST = 1'b1;
    sb.delete();
    last_owner = 1;
    last_a = 0;
    m0_req = 0; m1_req = 0; f0_req = 0; f1_req = 0;
    repeat (cycles) step();
    RST = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g0, g1;

    // Reset state
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_m0_gnt", {31'b0, m0_gnt}, 0);
    chk("rst_m1_gnt", {31'b0, m1_gnt}, 0);
    chk("rst_m0_rvalid", {31'b0, m0_rvalid}, 0);
    chk("rst_m1_rvalid", {31'b0, m1_rvalid}, 0);
    chk("rst_m0_err", {31'b0, m0_err}, 0);
    chk("rst_m1_err", {31'b0, m1_err}, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    chk("rst_rom_csn", {31'b0, rom_csn}, 1);
    chk("rst_rom_a", {22'b0, rom_a}, 0);
    do_reset(2);

    // Single fetch from word 0
    m0_req = 1; m0_addr = 32'h000;
    step();
    m0_req = 0;
    step();

    // Contention: both ports held for 4 cycles
    m0_req = 1; m0_addr = 32'h004;
    m1_req = 1; m1_addr = 32'h008;
    repeat (4) step();
    m0_req = 0; m1_req = 0;
    step();

    // Out of range on port 1, with stray high and byte-lane bits on another access
    m1_req = 1; m1_addr = 32'h0000_0C80;
    step();
    m1_addr = 32'hFFFF_F07F;
    step();
    m1_req = 0;
    step();

    // Back-to-back fetches, no bubble
    m0_req = 1; m0_addr = 32'h07C;
    step();
    m0_addr = 32'h080;
    step();
    m0_req = 0;
    step();

    // Reset in the cycle after a grant drops the response and restores port 0 priority
    m0_req = 1; m0_addr = 32'h010;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    sb.delete();
    last_owner = 1;
    last_a = 0;
    m0_req = 0;
    @(negedge CLK);
    chk("midrst_m0_rvalid", {31'b0, m0_rvalid}, 0);
    chk("midrst_rdata", m0_rdata, 0);
    step();
    RST = 1'b0;
    m0_req = 1; m0_addr = 32'h014;
    m1_req = 1; m1_addr = 32'h018;
    @(negedge CLK);
    chk("post_rst_tie_m0", {31'b0, m0_gnt}, 1);
    step();
    m0_req = 0; m1_req = 0;
    step();

    // Fixed-priority instance: port 0 always wins while requesting
    f0_req = 1; f0_addr = 32'h000;
    f1_req = 1; f1_addr = 32'h07C;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("fp_m0_gnt", {31'b0, fp_m0_gnt}, 1);
      chk("fp_m1_gnt", {31'b0, fp_m1_gnt}, 0);
      if (i > 0) chk("fp_m0_rdata", fp_m0_rdata, 32'h0000_0013);
      step();
    end
    f0_req = 0;
    @(negedge CLK);
    chk("fp_m1_gnt_alone", {31'b0, fp_m1_gnt}, 1);
    chk("fp_m0_rvalid_last", {31'b0, fp_m0_rvalid}, 1);
    step();
    f1_req = 0;
    @(negedge CLK);
    chk("fp_m1_rvalid", {31'b0, fp_m1_rvalid}, 1);
    chk("fp_m1_rdata", fp_m1_rdata, 32'h0100_006F);
    chk("fp_m1_err", {31'b0, fp_m1_err}, 0);
    step();

    // Random traffic: requests held until granted, occasionally withdrawn
    g0 = 0; g1 = 0;
    for (int n = 0; n < 400; n++) begin
      if (!m0_req || g0 || ($urandom_range(0, 15) == 0)) begin
        m0_req  = ($urandom_range(0, 3) != 0);
        m0_addr = ($urandom & ~32'hFFC) | (32'($urandom_range(0, 1023)) << 2);
      end
      if (!m1_req || g1 || ($urandom_range(0, 15) == 0)) begin
        m1_req  = ($urandom_range(0, 2) != 0);
        m1_addr = ($urandom & ~32'hFFC) | (32'($urandom_range(0, 1023)) << 2);
      end
      @(negedge CLK);
      g0 = m0_gnt;
      g1 = m1_gnt;
      step();
    end
    m0_req = 0; m1_req = 0;
    repeat (3) step();

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending responses expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
